// File: rtl/sram_dp_ctrl.sv
// Simple-dual-port SRAM wrapper with per-byte writes, a valid-qualified read path
// (1 or 2 cycles), defined same-address read-during-write, and an init/clear sweep.
module sram_dp_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 3072,
    parameter int                    BYTE_W     = 8,
    parameter int                    RD_LATENCY = 1,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_write,
    input  logic [$clog2(DEPTH)-1:0]       i_addr_wr,
    input  logic [DATA_WIDTH-1:0]          i_data,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   i_be,
    input  logic                           i_read,
    input  logic [$clog2(DEPTH)-1:0]       i_addr_r,
    input  logic                           i_clear,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_valid,
    output logic                           o_init_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_WIDTH / BYTE_W;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    logic                  run;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  rd_in_range;
    logic                  rdw_hit;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_wbe;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign run         = (state_q == ST_RUN);
    assign wr_ok       = run && i_write && ({1'b0, i_addr_wr} < DEPTH_EXT);
    assign rd_ok       = run && i_read;
    assign rd_in_range = ({1'b0, i_addr_r} < DEPTH_EXT);
    assign rdw_hit     = (RDW_MODE == 1) && wr_ok && (i_addr_wr == i_addr_r);

    // The sweep owns the write port while in INIT; i_clear always restarts it at 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = i_addr_wr;
        mem_wdata = i_data;
        mem_wbe   = i_be;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = INIT_VALUE;
            mem_wbe   = '1;
            if (i_clear) begin
                cnt_d = '0;
            end else if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end else begin
            mem_we = wr_ok;
            if (i_clear) begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        old_word = rd_in_range ? mem[i_addr_r] : '0;
        rd_word  = old_word;
        for (int k = 0; k < NB; k++) begin
            if (rdw_hit && i_be[k]) begin
                rd_word[k*BYTE_W +: BYTE_W] = i_data[k*BYTE_W +: BYTE_W];
            end
        end
        s1_valid_d = rd_ok;
        s1_data_d  = rd_ok ? rd_word : s1_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_waddr][k*BYTE_W +: BYTE_W] <= mem_wdata[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  out_valid_q, out_valid_d;
            logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

            always_comb begin
                out_valid_d = s1_valid_q;
                out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= out_valid_d;
                    out_data_q  <= out_data_d;
                end
            end

            assign o_valid = out_valid_q;
            assign o_data  = out_data_q;
        end else begin : g_lat1
            assign o_valid = s1_valid_q;
            assign o_data  = s1_data_q;
        end
    endgenerate

    assign o_init_done = run;

endmodule

// File: tb/tb_sram_dp_ctrl.sv
// Directed bench for sram_dp_ctrl: two instances share one stimulus stream,
// A = 16 words / latency 1 / old-data RDW, B = 12 words / latency 2 / merged RDW.
module tb_sram_dp_ctrl;

    localparam int          DW     = 32;
    localparam int          NB     = 4;
    localparam int          AW     = 4;
    localparam logic [31:0] INIT_B = 32'h5A5A_C3C3;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          wr      = 1'b0;
    logic [AW-1:0] addr_wr = '0;
    logic [DW-1:0] wdata   = '0;
    logic [NB-1:0] be      = '0;
    logic          rd      = 1'b0;
    logic [AW-1:0] addr_r  = '0;
    logic          clr     = 1'b0;

    logic [DW-1:0] data_a, data_b;
    logic          valid_a, valid_b;
    logic          done_a, done_b;

    int check_count = 0;
    int fail_count  = 0;

    always #5 clk = ~clk;

    sram_dp_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(16), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0),
        .INIT_VALUE(32'h0)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_write(wr), .i_addr_wr(addr_wr),
        .i_data(wdata), .i_be(be), .i_read(rd), .i_addr_r(addr_r), .i_clear(clr),
        .o_data(data_a), .o_valid(valid_a), .o_init_done(done_a)
    );

    sram_dp_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(12), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(1),
        .INIT_VALUE(INIT_B)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_write(wr), .i_addr_wr(addr_wr),
        .i_data(wdata), .i_be(be), .i_read(rd), .i_addr_r(addr_r), .i_clear(clr),
        .o_data(data_b), .o_valid(valid_b), .o_init_done(done_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven at the falling edge, held across one rising edge, then idled.
    task automatic applyStimulus(input logic w, input logic [AW-1:0] aw, input logic [DW-1:0] d,
                                 input logic [NB-1:0] b, input logic r, input logic [AW-1:0] ar,
                                 input logic c);
        wr = w; addr_wr = aw; wdata = d; be = b; rd = r; addr_r = ar; clr = c;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; be = '0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic checkSweep(input string tag);
        for (int k = 1; k <= 16; k++) begin
            idleCycle();
            if (k == 11) checkOutput({tag, "_b_k11"}, 32'(done_b), 32'd0);
            if (k == 12) checkOutput({tag, "_b_k12"}, 32'(done_b), 32'd1);
            if (k == 15) checkOutput({tag, "_a_k15"}, 32'(done_a), 32'd0);
            if (k == 16) checkOutput({tag, "_a_k16"}, 32'(done_a), 32'd1);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid_a", 32'(valid_a), 32'd0);
        checkOutput("rst_valid_b", 32'(valid_b), 32'd0);
        checkOutput("rst_data_a", data_a, 32'd0);
        checkOutput("rst_data_b", data_b, 32'd0);
        checkOutput("rst_done_a", 32'(done_a), 32'd0);
        checkOutput("rst_done_b", 32'(done_b), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First sweep, with a write+read attempt while not yet initialised.
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) applyStimulus(1'b1, 4'd1, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd1, 1'b0);
            else        idleCycle();
            if (k == 3 || k == 4) begin
                checkOutput($sformatf("early_valid_a_k%0d", k), 32'(valid_a), 32'd0);
                checkOutput($sformatf("early_valid_b_k%0d", k), 32'(valid_b), 32'd0);
            end
            if (k == 11) checkOutput("init_b_k11", 32'(done_b), 32'd0);
            if (k == 12) checkOutput("init_b_k12", 32'(done_b), 32'd1);
            if (k == 15) checkOutput("init_a_k15", 32'(done_a), 32'd0);
            if (k == 16) checkOutput("init_a_k16", 32'(done_a), 32'd1);
        end

        // Back-to-back reads of every address; B lags by one and returns 0 past word 11.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'(i), 1'b0);
            checkOutput($sformatf("rdall_a_valid%0d", i), 32'(valid_a), 32'd1);
            checkOutput($sformatf("rdall_a_data%0d", i), data_a, 32'd0);
            if (i == 0) begin
                checkOutput("rdall_b_valid_first", 32'(valid_b), 32'd0);
            end else begin
                checkOutput($sformatf("rdall_b_valid%0d", i - 1), 32'(valid_b), 32'd1);
                checkOutput($sformatf("rdall_b_data%0d", i - 1), data_b, (i - 1 < 12) ? INIT_B : 32'd0);
            end
        end
        idleCycle();
        checkOutput("rdall_a_valid_end", 32'(valid_a), 32'd0);
        checkOutput("rdall_b_valid15", 32'(valid_b), 32'd1);
        checkOutput("rdall_b_data15", data_b, 32'd0);
        idleCycle();
        checkOutput("rdall_b_valid_end", 32'(valid_b), 32'd0);

        // Byte-enable merging, including an all-zero enable that must not write.
        applyStimulus(1'b1, 4'd5, 32'hAABB_CCDD, 4'b1111, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 4'd5, 32'h1122_3344, 4'b0101, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        checkOutput("be_a_valid", 32'(valid_a), 32'd1);
        checkOutput("be_a_data", data_a, 32'hAA22_CC44);
        idleCycle();
        checkOutput("be_b_data", data_b, 32'hAA22_CC44);
        checkOutput("be_a_hold_valid", 32'(valid_a), 32'd0);
        checkOutput("be_a_hold_data", data_a, 32'hAA22_CC44);

        // Same-cycle same-address read/write on addr 3.
        applyStimulus(1'b1, 4'd3, 32'hDEAD_BE12, 4'b1111, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 4'd3, 32'h0000_0055, 4'b0001, 1'b1, 4'd3, 1'b0);
        checkOutput("rdw_a_old", data_a, 32'hDEAD_BE12);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        checkOutput("rdw_a_after", data_a, 32'hDEAD_BE55);
        checkOutput("rdw_b_merged", data_b, 32'hDEAD_BE55);
        idleCycle();
        checkOutput("rdw_b_after", data_b, 32'hDEAD_BE55);

        // Write one cycle after a read of the same address must not leak into B's pipeline.
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);
        checkOutput("late_wr_a_old", data_a, 32'd0);
        applyStimulus(1'b1, 4'd7, 32'hCAFE_F00D, 4'b1111, 1'b0, '0, 1'b0);
        checkOutput("late_wr_b_old", data_b, INIT_B);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);
        checkOutput("late_wr_a_new", data_a, 32'hCAFE_F00D);
        idleCycle();
        checkOutput("late_wr_b_new", data_b, 32'hCAFE_F00D);

        // Address 13 is in range for A but out of range for B.
        applyStimulus(1'b1, 4'd13, 32'h0BAD_F00D, 4'b1111, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd13, 1'b0);
        checkOutput("oob_a_data", data_a, 32'h0BAD_F00D);
        idleCycle();
        checkOutput("oob_b_valid", 32'(valid_b), 32'd1);
        checkOutput("oob_b_data", data_b, 32'd0);

        // Clear with a read in flight, then a blocked read, then the re-sweep.
        applyStimulus(1'b1, 4'd9, 32'h1234_5678, 4'b1111, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b1);
        checkOutput("clr_a_valid", 32'(valid_a), 32'd1);
        checkOutput("clr_a_data", data_a, 32'h1234_5678);
        checkOutput("clr_a_done", 32'(done_a), 32'd0);
        checkOutput("clr_b_done", 32'(done_b), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 1) applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
            else        idleCycle();
            if (k == 1) begin
                checkOutput("clr_blocked_a_valid", 32'(valid_a), 32'd0);
                checkOutput("clr_b_valid", 32'(valid_b), 32'd1);
                checkOutput("clr_b_data", data_b, 32'h1234_5678);
            end
            if (k == 2)  checkOutput("clr_blocked_b_valid", 32'(valid_b), 32'd0);
            if (k == 11) checkOutput("clr_b_k11", 32'(done_b), 32'd0);
            if (k == 12) checkOutput("clr_b_k12", 32'(done_b), 32'd1);
            if (k == 15) checkOutput("clr_a_k15", 32'(done_a), 32'd0);
            if (k == 16) checkOutput("clr_a_k16", 32'(done_a), 32'd1);
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
        checkOutput("clr_reinit_a", data_a, 32'd0);
        idleCycle();
        checkOutput("clr_reinit_b", data_b, INIT_B);

        // Reset with B's read still in its pipeline.
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid_a", 32'(valid_a), 32'd0);
        checkOutput("rst_mid_data_b", data_b, 32'd0);
        checkOutput("rst_mid_done_b", 32'(done_b), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            idleCycle();
            if (k == 1) checkOutput("rst_lost_valid_b", 32'(valid_b), 32'd0);
        end

        // Reset in the middle of the sweep restarts it from scratch.
        rst_n = 1'b0;
        #1;
        checkOutput("rst_sweep_done_b", 32'(done_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkSweep("resweep");

        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd0, 1'b0);
        checkOutput("final_a_data", data_a, 32'd0);
        idleCycle();
        checkOutput("final_b_data", data_b, INIT_B);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
